// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART transmit peripheral: register map,
// STATUS/CTRL bit positions, FSM state encoding and a divisor helper.
package uart_io_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_FULL    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;
   localparam int STAT_CNT_W   = 3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // A divisor below 2 would make a bit shorter than the counter can time.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd2 : d;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with separate occupancy count. Flush overrides push/pop.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on one I/O decoder slot.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | line high; starts a frame when enabled and FIFO non-empty
// ST_START | start bit (low) for div_q cycles
// ST_DATA  | 8 data bits, LSB first, div_q cycles each
// ST_STOP  | stop bit (high) for div_q cycles, then back to idle
module uart_tx_io
   import uart_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RESET  = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [18:0] dev_bus,
   input  logic        cs,
   output logic [15:0] rdata,
   output logic        tx,
   output logic        busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   logic        we;
   logic [1:0]  reg_sel;
   logic [15:0] wdata;
   logic        wr;

   logic        push_req;
   logic        flush_req;
   logic        ovf_set;
   logic        ovf_clr;
   logic        pop;

   logic             ovf;
   logic             en;
   logic [15:0]      div;
   logic [15:0]      status;

   logic [7:0]       fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   tx_state_t   state;
   logic [7:0]  shift;
   logic [2:0]  bitcnt;
   logic [15:0] baud_cnt;
   logic [15:0] div_q;
   logic        bit_end;

   assign {we, reg_sel, wdata} = dev_bus;
   assign wr        = cs && we;
   assign push_req  = wr && (reg_sel == REG_DATA);
   assign flush_req = wr && (reg_sel == REG_CTRL) && wdata[CTRL_FLUSH];
   assign ovf_clr   = wr && (reg_sel == REG_STATUS) && wdata[STAT_OVF];
   assign pop       = (state == ST_IDLE) && en && !fifo_empty;
   assign ovf_set   = push_req && fifo_full && !pop && !flush_req;
   assign bit_end   = (baud_cnt == div_q - 16'd1);
   assign busy      = (state != ST_IDLE);

   io_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .flush (flush_req),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Register file: sticky overflow (set beats clear), divisor, enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
         div <= 16'(DIV_RESET);
         en  <= 1'b0;
      end else begin
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         if (wr && (reg_sel == REG_DIV))  div <= wdata;
         if (wr && (reg_sel == REG_CTRL)) en  <= wdata[CTRL_EN];
      end
   end

   // STATUS word assembly.
   always_comb begin
      status                                = '0;
      status[STAT_BUSY]                     = busy;
      status[STAT_EMPTY]                    = fifo_empty;
      status[STAT_FULL]                     = fifo_full;
      status[STAT_OVF]                      = ovf;
      status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
   end

   // Zero-latency read mux, independent of chip-select.
   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_DATA:   rdata = '0;
         REG_STATUS: rdata = status;
         REG_DIV:    rdata = div;
         REG_CTRL:   rdata = {15'd0, en};
         default:    rdata = '0;
      endcase
   end

   // Frame sequencer, baud counter and registered tx line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         shift    <= '0;
         bitcnt   <= '0;
         baud_cnt <= '0;
         div_q    <= 16'd2;
         tx       <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift    <= fifo_dout;
                  div_q    <= eff_div(div);
                  bitcnt   <= '0;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= shift[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bitcnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     shift  <= {1'b0, shift[7:1]};
                     tx     <= shift[1];
                     bitcnt <= bitcnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: directed register/timing checks plus a frame
// scoreboard fed at write time and drained by a serial-line monitor.
module tb_uart_tx_io;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [18:0] dev_bus = '0;
   logic        cs = 1'b0;
   logic [15:0] rdata;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int mon_div  = 4;
   logic [7:0] exp_q[$];

   uart_tx_io #(
      .FIFO_DEPTH (4),
      .DIV_RESET  (868)
   ) dut (
      .clk     (clk),
      .reset   (rst),
      .dev_bus (dev_bus),
      .cs      (cs),
      .rdata   (rdata),
      .tx      (tx),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [15:0] d);
      cs      = 1'b1;
      dev_bus = {1'b1, sel, d};
      @(posedge clk);
      #1;
      cs      = 1'b0;
      dev_bus = {1'b0, sel, 16'h0000};
   endtask

   task automatic rd(input logic [1:0] sel, input logic [15:0] exp, input string name);
      dev_bus = {1'b0, sel, 16'h0000};
      #1;
      chk(name, {16'h0, rdata}, {16'h0, exp});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serial-line monitor: on each start edge pop the expected byte and
   // compare every cycle of the 10-bit frame; a reset aborts the frame.
   initial begin
      logic       prev_tx;
      logic [7:0] exp_b;
      logic [9:0] frame;
      logic       ok;
      logic       aborted;
      int         bad_c;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && prev_tx === 1'b1 && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got start bit expected idle line");
            end else begin
               exp_b   = exp_q.pop_front();
               frame   = {1'b1, exp_b, 1'b0};
               ok      = 1'b1;
               aborted = 1'b0;
               bad_c   = -1;
               for (int c = 0; c < 10 * mon_div; c++) begin
                  if (c > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx !== frame[c / mon_div] && ok) begin
                     ok    = 1'b0;
                     bad_c = c;
                  end
               end
               if (!aborted) begin
                  n_checks++;
                  if (!ok) begin
                     n_fail++;
                     $display("FAIL frame_0x%02h: got wrong line level at cycle %0d expected frame bits 0x%03h",
                              exp_b, bad_c, frame);
                  end
               end
            end
         end
         prev_tx = tx;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      int nstarts;
      int starts[4];
      int fall_k;
      int highs;
      logic prev_b;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc(1);

      // Reset state
      chk("tx_reset", tx, 1);
      chk("busy_reset", busy, 0);
      rd(2'd1, 16'h0002, "status_reset");
      rd(2'd2, 16'd868, "div_reset");
      rd(2'd3, 16'h0000, "ctrl_reset");
      rd(2'd0, 16'h0000, "data_reads_zero");

      // Single frame 0xA5 at divisor 4
      wr(2'd2, 16'd4);
      wr(2'd3, 16'h0001);
      mon_div = 4;
      exp_q.push_back(8'hA5);
      wr(2'd0, 16'h00A5);
      chk("tx_high_at_write", tx, 1);
      @(posedge clk);
      #1;
      chk("tx_start_low", tx, 0);
      chk("busy_start", busy, 1);
      n = 1;
      for (int i = 0; i < 200 && busy; i++) begin
         @(posedge clk);
         #1;
         if (busy) n++;
      end
      chk("busy_len_a5", n, 40);
      rd(2'd2, 16'd4, "div_readback");

      // Overflow and sticky clear with the transmitter disabled
      wr(2'd3, 16'h0000);
      for (int i = 0; i < 5; i++) wr(2'd0, 16'(8'h10 + i));
      rd(2'd1, 16'h004C, "status_full_ovf");
      wr(2'd1, 16'h0008);
      rd(2'd1, 16'h0044, "status_ovf_clr");
      wr(2'd3, 16'h0002);
      rd(2'd1, 16'h0002, "status_flushed");
      rd(2'd3, 16'h0000, "ctrl_flush_reads0");

      // Three back-to-back frames at divisor 2
      wr(2'd2, 16'd2);
      mon_div = 2;
      exp_q.push_back(8'h3C); wr(2'd0, 16'h003C);
      exp_q.push_back(8'h81); wr(2'd0, 16'h0081);
      exp_q.push_back(8'h7E); wr(2'd0, 16'h007E);
      rd(2'd1, 16'h0030, "status_three");
      wr(2'd3, 16'h0001);
      chk("busy_before_pop", busy, 0);
      nstarts = 0;
      fall_k  = -1;
      highs   = 0;
      prev_b  = 1'b0;
      for (k = 0; k < 80; k++) begin
         @(posedge clk);
         #1;
         if (busy) highs++;
         if (busy && !prev_b && nstarts < 4) begin
            starts[nstarts] = k;
            nstarts++;
         end
         if (!busy && prev_b) fall_k = k;
         prev_b = busy;
      end
      chk("b2b_frames", nstarts, 3);
      chk("b2b_start2", starts[1], 21);
      chk("b2b_start3", starts[2], 42);
      chk("b2b_last_fall", fall_k, 62);
      chk("b2b_busy_cycles", highs, 60);

      // Push on the pop edge while full, then flush mid-frame
      wr(2'd3, 16'h0000);
      exp_q.push_back(8'h5A);
      wr(2'd0, 16'h005A);
      wr(2'd0, 16'h0011);
      wr(2'd0, 16'h0022);
      wr(2'd0, 16'h0033);
      rd(2'd1, 16'h0044, "status_full_no_ovf");
      wr(2'd3, 16'h0001);
      wr(2'd0, 16'h0044);
      rd(2'd1, 16'h0045, "status_push_on_pop");
      wr(2'd3, 16'h0003);
      rd(2'd1, 16'h0003, "status_flush_midframe");
      for (int i = 0; i < 100 && busy; i++) cyc(1);
      chk("frame_done_after_flush", busy, 0);
      cyc(30);
      chk("no_frame_after_flush", busy, 0);
      rd(2'd1, 16'h0002, "status_idle_after_flush");

      // Asynchronous reset in the middle of a data bit
      wr(2'd2, 16'd4);
      mon_div = 4;
      exp_q.push_back(8'h00);
      wr(2'd0, 16'h0000);
      wr(2'd0, 16'h00FF);
      cyc(7);
      chk("tx_low_in_data", tx, 0);
      chk("busy_in_data", busy, 1);
      rst = 1'b1;
      #1;
      chk("tx_async_reset", tx, 1);
      chk("busy_async_reset", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1);
      rd(2'd1, 16'h0002, "status_after_reset");
      rd(2'd2, 16'd868, "div_after_reset");
      rd(2'd3, 16'h0000, "ctrl_after_reset");

      cyc(5);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_io.md
# uart_tx_io

Memory-mapped UART transmitter peripheral for the I/O bus of the simple machine. It sits directly downstream of the I/O decoder and occupies one device slot: it consumes that slot's 19-bit `{we, reg_sel, data}` bundle and its chip-select, and returns 16-bit read data to the decoder's read mux. Bytes written by the CPU are buffered in a small FIFO and serialised as 8N1 frames on `tx`.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; must be a power of two.
- `DIV_RESET`, 868: reset value of the divisor register, in clk cycles per bit.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `dev_bus` input 19: `{we, reg_sel[1:0], wdata[15:0]}` from the decoder slot.
- `cs` input 1: chip-select from the decoder.
- `rdata` output 16: combinational read data, selected by `reg_sel` regardless of `cs`.
- `tx` output 1: serial line, registered, idles high.
- `busy` output 1: high when the FSM is not IDLE.

## Operation
- A write happens on every rising edge where `cs && we`. The CPU holds `we` for exactly one cycle per store.
- Register 0, DATA:
  - Write pushes `wdata[7:0]`.
  - If the FIFO is full and no pop occurs that same cycle, the byte is dropped and `ovf` is set.
  - Reads return 0.
- Register 1, STATUS (read):
  - bit0 `busy`, bit1 `empty`, bit2 `full`, bit3 `ovf` (sticky), bits[6:4] `count` (0..FIFO_DEPTH); other bits 0.
  - Writing with `wdata[3]=1` clears `ovf`. If an overflow occurs in the same cycle, set wins.
- Register 2, DIV: read/write, 16 bits. The value is latched into `div_q` when a frame starts. Effective divisor is `max(DIV,2)`.
- Register 3, CTRL:
  - bit0 `en` (read/write, reset 0).
  - bit1 `flush` (write-only): writing 1 empties the FIFO; reads as 0.
  - If flush and push occur in the same cycle, flush wins and the byte is discarded.
  - A frame already in flight is unaffected by flush.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `en && !empty`, pop the head into the shift register, latch `div_q`, clear `bitcnt`, go to START.
  - START: `tx=0` for `div_q` cycles, then go to DATA.
  - DATA: drive `tx=shift[0]` for `div_q` cycles per bit, LSB first. After 8 bits, go to STOP.
  - STOP: `tx=1` for `div_q` cycles, then go to IDLE.
- Clearing `en` mid-frame lets the current frame finish; no new frame starts.
- The baud counter runs 0..`div_q`-1 and resets at each bit boundary.
- Reset values: FIFO empty, `ovf=0`, DIV=`DIV_RESET`, `en=0`, state IDLE, `tx=1`, `busy=0`.
- Reset asserted mid-frame: `tx` returns high immediately and the frame is lost.

## Timing
- Push at edge N means `count` increments as seen after edge N.
- With `en=1` and the FSM in IDLE, the pop occurs at edge N+1 and `tx` falls after edge N+1.
- Frame length is exactly 10·`div_q` cycles. `busy` is high for exactly those cycles.
- Exactly one IDLE cycle separates back-to-back frames.
- A push and a pop in the same cycle leave `count` unchanged, including when the FIFO is full.
- `rdata` has zero latency (combinational from `reg_sel` and state).

## Structure
- Package `uart_io_pkg` holds:
  - register address constants (`REG_DATA=0`, `REG_STATUS=1`, `REG_DIV=2`, `REG_CTRL=3`);
  - STATUS bit-position constants;
  - the FSM state enum.
- Sub-module `io_fifo`: synchronous FIFO, parameterised width 8 and depth FIFO_DEPTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Pointers wrap modulo depth; the count is held separately.
- The top level contains the register file, the FSM, the baud counter and the `tx` flop.

## Test plan
- Reset, then read all registers: STATUS=0x0002, DIV=868, CTRL=0, and `tx=1`.
- DIV=4, `en=1`, write 0xA5: `tx` goes low 1 cycle after the write. The line shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `busy` is high for 40 cycles.
- With `en=0`, write 5 bytes: count=4, full=1, ovf=1. Write STATUS with bit3 set: ovf=0, FIFO unchanged.
- DIV=2, `en=1`, three queued bytes: three frames of 20 cycles each, with a 1-cycle idle gap between frames. Last `busy` falls 62 cycles after the first pop.
- FIFO full while a frame starts: push on the same edge as the pop is accepted and count stays 4. Flush mid-frame: the current frame completes and no further frames are sent.
- Reset asserted mid-DATA with `tx=0`: `tx=1` and `busy=0` asynchronously. After release, the FIFO is empty and DIV=868.
